// File: rtl/mux_st.sv
// Store-operand formatter: sign-extends the rs2 operand to the store size and
// registers the lane-aligned write data, byte enables and status flags.
module mux_st (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rs2_data_tmp,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        st_en,
    output logic [31:0] rs2_data,
    output logic [31:0] wdata_q,
    output logic [3:0]  byte_en_q,
    output logic        valid_q,
    output logic        misalign_q,
    output logic        illegal_q
);

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    logic [31:0] wdata_d;
    logic [3:0]  byte_en_d;
    logic        valid_d;
    logic        misalign_d;
    logic        illegal_d;
    logic        is_legal;
    logic        is_misaligned;

    always_comb begin
        rs2_data = 32'h0000_0000;
        case (funct3)
            F3_SB:   rs2_data = {{24{rs2_data_tmp[7]}}, rs2_data_tmp[7:0]};
            F3_SH:   rs2_data = {{16{rs2_data_tmp[15]}}, rs2_data_tmp[15:0]};
            F3_SW:   rs2_data = rs2_data_tmp;
            default: rs2_data = 32'h0000_0000;
        endcase
    end

    always_comb begin
        is_legal      = 1'b0;
        is_misaligned = 1'b0;
        case (funct3)
            F3_SB: is_legal = 1'b1;
            F3_SH: begin
                is_legal      = 1'b1;
                is_misaligned = addr_lo[0];
            end
            F3_SW: begin
                is_legal      = 1'b1;
                is_misaligned = (addr_lo != 2'b00);
            end
            default: is_legal = 1'b0;
        endcase
    end

    // wdata is captured on every issued store, even faulting ones; only the
    // enables and valid qualify it.
    always_comb begin
        wdata_d    = wdata_q;
        byte_en_d  = 4'b0000;
        valid_d    = 1'b0;
        misalign_d = 1'b0;
        illegal_d  = 1'b0;
        if (st_en) begin
            if (funct3 == F3_SW) begin
                wdata_d = rs2_data;
            end else begin
                wdata_d = rs2_data << {addr_lo, 3'b000};
            end
            if (!is_legal) begin
                illegal_d = 1'b1;
            end else if (is_misaligned) begin
                misalign_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                case (funct3)
                    F3_SB:   byte_en_d = 4'b0001 << addr_lo;
                    F3_SH:   byte_en_d = 4'b0011 << addr_lo;
                    default: byte_en_d = 4'b1111;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdata_q    <= 32'h0000_0000;
            byte_en_q  <= 4'b0000;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            wdata_q    <= wdata_d;
            byte_en_q  <= byte_en_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            illegal_q  <= illegal_d;
        end
    end

endmodule

// File: tb/tb_mux_st.sv
// Directed bench for mux_st: the driver pushes hand-computed registered
// results into a scoreboard that a separate monitor drains one per edge.
module tb_mux_st;

    logic        clk;
    logic        rst;
    logic [31:0] rs2_data_tmp;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic        st_en;
    logic [31:0] rs2_data;
    logic [31:0] wdata_q;
    logic [3:0]  byte_en_q;
    logic        valid_q;
    logic        misalign_q;
    logic        illegal_q;

    typedef struct packed {
        logic        rst;
        logic        st_en;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
        logic [31:0] tmp;
        logic [31:0] exp_rs2;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic        exp_valid;
        logic        exp_mis;
        logic        exp_ill;
    } vec_t;

    typedef struct packed {
        logic [7:0]  idx;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        valid;
        logic        mis;
        logic        ill;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic drive_done = 1'b0;

    mux_st dut (
        .clk          (clk),
        .rst          (rst),
        .rs2_data_tmp (rs2_data_tmp),
        .funct3       (funct3),
        .addr_lo      (addr_lo),
        .st_en        (st_en),
        .rs2_data     (rs2_data),
        .wdata_q      (wdata_q),
        .byte_en_q    (byte_en_q),
        .valid_q      (valid_q),
        .misalign_q   (misalign_q),
        .illegal_q    (illegal_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s vec=%0d got=%h expected=%h", name, idx, actual, expected);
        end
    endtask

    task automatic addVec(input logic r, input logic s, input logic [2:0] f,
                          input logic [1:0] a, input logic [31:0] t,
                          input logic [31:0] er, input logic [31:0] ew,
                          input logic [3:0] eb, input logic ev, input logic em,
                          input logic ei);
        vec_t v;
        v = '{r, s, f, a, t, er, ew, eb, ev, em, ei};
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input int idx);
        vec_t v;
        exp_t e;
        v = vecs[idx];
        @(negedge clk);
        rst          = v.rst;
        st_en        = v.st_en;
        funct3       = v.funct3;
        addr_lo      = v.addr_lo;
        rs2_data_tmp = v.tmp;
        e = '{idx[7:0], v.exp_wdata, v.exp_be, v.exp_valid, v.exp_mis, v.exp_ill};
        sb.push_back(e);
        #1;
        checkOutput("rs2_data", idx, rs2_data, v.exp_rs2);
    endtask

    // Monitor: one scoreboard entry per rising edge once the driver has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("wdata_q",    int'(e.idx), wdata_q,            e.wdata);
                checkOutput("byte_en_q",  int'(e.idx), {28'd0, byte_en_q}, {28'd0, e.be});
                checkOutput("valid_q",    int'(e.idx), {31'd0, valid_q},   {31'd0, e.valid});
                checkOutput("misalign_q", int'(e.idx), {31'd0, misalign_q},{31'd0, e.mis});
                checkOutput("illegal_q",  int'(e.idx), {31'd0, illegal_q}, {31'd0, e.ill});
            end
        end
    end

    initial begin
        int budget;
        rst          = 1'b1;
        st_en        = 1'b0;
        funct3       = 3'b001;
        addr_lo      = 2'b00;
        rs2_data_tmp = 32'h1000_F0EE;
        #1;
        checkOutput("rs2_data_sh_noclk", -1, rs2_data, 32'hFFFF_F0EE);

        //     rst  st  f3      a      tmp           rs2           wdata         be      v  m  i
        addVec(1, 1, 3'b010, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 4'b0000, 0, 0, 0);
        addVec(0, 1, 3'b010, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 1, 0, 0);
        addVec(0, 1, 3'b000, 2'b11, 32'h0000_00A5, 32'hFFFF_FFA5, 32'hA500_0000, 4'b1000, 1, 0, 0);
        addVec(0, 1, 3'b001, 2'b01, 32'h1000_F0EE, 32'hFFFF_F0EE, 32'hFFF0_EE00, 4'b0000, 0, 1, 0);
        addVec(0, 1, 3'b011, 2'b01, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 4'b0000, 0, 0, 1);
        addVec(0, 0, 3'b000, 2'b00, 32'h1234_5680, 32'hFFFF_FF80, 32'h0000_0000, 4'b0000, 0, 0, 0);
        addVec(0, 1, 3'b000, 2'b01, 32'h1234_567F, 32'h0000_007F, 32'h0000_7F00, 4'b0010, 1, 0, 0);
        addVec(0, 1, 3'b001, 2'b10, 32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000, 4'b1100, 1, 0, 0);
        addVec(0, 1, 3'b010, 2'b10, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'hCAFE_BABE, 4'b0000, 0, 1, 0);
        addVec(0, 0, 3'b111, 2'b00, 32'h1111_1111, 32'h0000_0000, 32'hCAFE_BABE, 4'b0000, 0, 0, 0);
        addVec(0, 1, 3'b001, 2'b00, 32'h0000_7FFF, 32'h0000_7FFF, 32'h0000_7FFF, 4'b0011, 1, 0, 0);
        addVec(1, 1, 3'b000, 2'b00, 32'h0000_00FF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0000, 0, 0, 0);
        addVec(0, 0, 3'b010, 2'b00, 32'h5555_5555, 32'h5555_5555, 32'h0000_0000, 4'b0000, 0, 0, 0);
        addVec(0, 1, 3'b010, 2'b00, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 4'b1111, 1, 0, 0);
        addVec(0, 1, 3'b110, 2'b10, 32'h89AB_CDEF, 32'h0000_0000, 32'h0000_0000, 4'b0000, 0, 0, 1);
        addVec(0, 0, 3'b000, 2'b10, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 4'b0000, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(i);
        end
        @(negedge clk);
        st_en = 1'b0;

        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_drain left=%0d expected=0", sb.size());
        end
        drive_done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_st.md
MUX_ST -- requirements
Module: mux_st

Interface
REQ-001 The module SHALL have no parameters; the data width is fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all registers update on its rising edge.
REQ-003 rst  input  1  one clock; reset is synchronous and active-high.
REQ-004 rs2_data_tmp  input  32  raw store operand read from register file rs2.
REQ-005 funct3  input  3  RISC-V store size code: 000 SB, 001 SH, 010 SW, others illegal.
REQ-006 addr_lo  input  2  effective address bits [1:0] of the store.
REQ-007 st_en  input  1  store-issue strobe, one cycle per store.
REQ-008 rs2_data  output  32  combinational size-formatted store operand.
REQ-009 wdata_q  output  32  registered lane-aligned write data.
REQ-010 byte_en_q  output  4  registered byte-lane write enables; bit i enables byte i.
REQ-011 valid_q  output  1  registered: a legal, aligned store was issued last cycle.
REQ-012 misalign_q  output  1  registered misaligned-store flag.
REQ-013 illegal_q  output  1  registered illegal-funct3 flag.

Function
REQ-014 rs2_data SHALL be purely combinational from rs2_data_tmp and funct3, independent of clk, rst, st_en and addr_lo, and SHALL settle within the same time step as its inputs.
REQ-015 funct3=000: rs2_data SHALL be rs2_data_tmp[7:0] sign-extended to 32 bits.
REQ-016 funct3=001: rs2_data SHALL be rs2_data_tmp[15:0] sign-extended to 32 bits.
REQ-017 funct3=010: rs2_data SHALL equal rs2_data_tmp unchanged.
REQ-018 funct3 in 011..111: rs2_data SHALL be 32'h0000_0000.
REQ-019 Alignment: SB is always aligned; SH is misaligned when addr_lo[0]=1; SW is misaligned when addr_lo is not 00.
REQ-020 When st_en=1, on the next rising edge wdata_q SHALL capture rs2_data shifted left by 8*addr_lo bits (zero fill), or rs2_data unshifted for SW.
REQ-021 When st_en=1, legal funct3 and aligned: byte_en_q SHALL be 0001 shifted left by addr_lo for SB, 0011 shifted left by addr_lo for SH, and 1111 for SW; valid_q=1; misalign_q=0; illegal_q=0.
REQ-022 When st_en=1 and misaligned: byte_en_q=0000, valid_q=0, misalign_q=1, illegal_q=0.
REQ-023 When st_en=1 and funct3 is illegal: byte_en_q=0000, valid_q=0, illegal_q=1, misalign_q=0; illegal takes priority over misalignment.
REQ-024 When st_en=0: byte_en_q, valid_q, misalign_q and illegal_q SHALL clear to 0 on the next edge, and wdata_q SHALL hold its value.
REQ-025 Registered outputs SHALL have exactly one cycle of latency from st_en, with no back-pressure or stall.

Reset
REQ-026 If rst=1 at a rising edge, wdata_q, byte_en_q, valid_q, misalign_q and illegal_q SHALL all be 0 after that edge; rst overrides st_en on the same edge.
REQ-027 rs2_data SHALL be unaffected by rst.
REQ-028 After rst deasserts, the first st_en SHALL be processed normally on the next edge.

Verification
REQ-029 funct3=001, rs2_data_tmp=32'h1000_F0EE -> rs2_data=32'hFFFF_F0EE within 1 time unit, with no clock edge needed.
REQ-030 funct3=000, rs2_data_tmp=32'h1234_5680 -> rs2_data=32'hFFFF_FF80; with 32'h1234_567F -> rs2_data=32'h0000_007F.
REQ-031 funct3=010, rs2_data_tmp=32'hDEAD_BEEF, addr_lo=00, st_en=1, then one edge -> rs2_data=32'hDEAD_BEEF, wdata_q=32'hDEAD_BEEF, byte_en_q=1111, valid_q=1.
REQ-032 funct3=000, rs2_data_tmp=32'h0000_00A5, addr_lo=11, st_en=1, then one edge -> wdata_q=32'hA500_0000, byte_en_q=1000, valid_q=1.
REQ-033 funct3=001, addr_lo=01, st_en=1, then one edge -> misalign_q=1, byte_en_q=0000, valid_q=0; funct3=011 -> rs2_data=0, then after one edge illegal_q=1.
REQ-034 rst=1 together with st_en=1 on the same edge -> all registered outputs are 0; with st_en=0 on the following edge, byte_en_q and the flags stay 0 and wdata_q holds.
